irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 169 ++++++++++++++++
 tb/tb_irq_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: four-source interrupt controller on the IO bus.
// Fixed-priority or round-robin arbitration with CPU ack and EOI.
//
// Ports
//   CLK, RESET    : clock, synchronous active-high reset
//   BUS_DATA      : shared 8-bit IO data bus (driven only for reads)
//   BUS_ADDR      : IO address, 0xE0-0xE3 decoded here
//   BUS_WE        : high for a CPU write
//   IRQ_RAISE     : per-source request levels
//   IRQ_ACK       : one-cycle ack pulse to the granted source
//   CPU_INT_RAISE : merged interrupt request to the CPU
//   CPU_INT_ACK   : one-cycle CPU acknowledge
//
// Registers
//   0xE0 CTRL  rw : [7] mode (1 = round-robin), [3:0] enable mask
//   0xE1 PEND  ro : [3:0] latched pending bits
//   0xE2 CUR   ro : [7] in-service valid, [1:0] granted id
//   0xE3 EOI   wo : any write in SERVICE ends the interrupt
module irq_controller (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] IRQ_RAISE,
  output logic [3:0] IRQ_ACK,
  output logic       CPU_INT_RAISE,
  input  logic       CPU_INT_ACK
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAISE   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] mask;
  logic       mode;
  logic [3:0] pend;
  logic       cur_valid;
  logic [1:0] cur_id;
  logic [1:0] last_grant;
  logic [7:0] rd_data;
  logic       rd_oe;

  logic       hit;
  logic       sel_ctrl;
  logic       sel_pend;
  logic       sel_cur;
  logic       sel_eoi;
  logic       wr_ctrl;
  logic       wr_eoi;
  logic [7:0] rd_mux;

  logic [3:0] eligible;
  logic       any_elig;
  logic [1:0] start;
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] pick_id;
  logic [3:0] ack_vec;
  logic [3:0] pend_clr;
  logic       ack_take;
  logic       unused_bits;

  assign unused_bits = ^BUS_DATA[6:4];

  // Address decode
  assign hit      = (BUS_ADDR[7:2] == 6'h38);
  assign sel_ctrl = hit && (BUS_ADDR[1:0] == 2'd0);
  assign sel_pend = hit && (BUS_ADDR[1:0] == 2'd1);
  assign sel_cur  = hit && (BUS_ADDR[1:0] == 2'd2);
  assign sel_eoi  = hit && (BUS_ADDR[1:0] == 2'd3);
  assign wr_ctrl  = BUS_WE && sel_ctrl;
  assign wr_eoi   = BUS_WE && sel_eoi;

  always_comb begin
    rd_mux = 8'h00;
    unique case (1'b1)
      sel_ctrl: rd_mux = {mode, 3'b000, mask};
      sel_pend: rd_mux = {4'h0, pend};
      sel_cur:  rd_mux = {cur_valid, 5'b0, cur_id};
      default:  rd_mux = 8'h00;
    endcase
  end

  assign BUS_DATA = rd_oe ? rd_data : 8'hzz;

  // Arbitration: rotate the eligible vector so the search
  // start sits at bit 0, take the lowest set bit, rotate back.
  // Fixed priority is the same search starting at 0.
  assign eligible = pend & mask;
  assign any_elig = |eligible;

  always_comb begin
    start = mode ? (last_grant + 2'd1) : 2'd0;
    dbl   = {eligible, eligible};
    rot   = dbl[{1'b0, start} +: 4];
    off   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    pick_id = start + off;
  end

  assign ack_vec  = 4'b0001 << cur_id;
  assign ack_take = (state == RAISE) && CPU_INT_ACK;
  // Clearing the acked bit overrides a same-cycle request.
  assign pend_clr = ack_take ? ack_vec : 4'h0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      mask          <= 4'h0;
      mode          <= 1'b0;
      pend          <= 4'h0;
      cur_valid     <= 1'b0;
      cur_id        <= 2'd0;
      last_grant    <= 2'd3;
      rd_data       <= 8'h00;
      rd_oe         <= 1'b0;
      IRQ_ACK       <= 4'h0;
      CPU_INT_RAISE <= 1'b0;
    end else begin
      IRQ_ACK <= 4'h0;
      rd_oe   <= !BUS_WE && hit;
      rd_data <= rd_mux;
      pend    <= (pend | IRQ_RAISE) & ~pend_clr;
      if (wr_ctrl) begin
        mask <= BUS_DATA[3:0];
        mode <= BUS_DATA[7];
      end
      case (state)
        IDLE: begin
          if (any_elig) begin
            cur_id        <= pick_id;
            state         <= RAISE;
            CPU_INT_RAISE <= 1'b1;
          end
        end
        RAISE: begin
          if (CPU_INT_ACK) begin
            IRQ_ACK       <= ack_vec;
            last_grant    <= cur_id;
            cur_valid     <= 1'b1;
            state         <= SERVICE;
            CPU_INT_RAISE <= 1'b0;
          end else if (!eligible[cur_id]) begin
            state         <= IDLE;
            CPU_INT_RAISE <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            cur_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          CPU_INT_RAISE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scoreboard bench for irq_controller.
// Directed scenarios then randomized rounds against a reference model.
module tb_irq_controller;

  localparam logic [7:0] A_CTRL = 8'hE0;
  localparam logic [7:0] A_PEND = 8'hE1;
  localparam logic [7:0] A_CUR  = 8'hE2;
  localparam logic [7:0] A_EOI  = 8'hE3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       we;
  logic [3:0] raise;
  logic       cpu_ack;
  wire  [3:0] irq_ack;
  wire        cpu_int_raise;
  tri1  [7:0] bus_data;
  logic       tb_drv;
  logic [7:0] tb_wdata;

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  always #5 clk = ~clk;

  irq_controller dut (
    .CLK          (clk),
    .RESET        (rst),
    .BUS_DATA     (bus_data),
    .BUS_ADDR     (addr),
    .BUS_WE       (we),
    .IRQ_RAISE    (raise),
    .IRQ_ACK      (irq_ack),
    .CPU_INT_RAISE(cpu_int_raise),
    .CPU_INT_ACK  (cpu_ack)
  );

  int checks = 0;
  int fails  = 0;
  logic [3:0] exp_ack[$];
  logic [7:0] exp_rd[$];
  logic       rd_flag = 1'b0;
  bit         mon_on  = 1'b0;

  logic [3:0] m_pend;
  logic [3:0] m_mask;
  bit         m_mode;
  int         m_last;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] e, input bit rr,
                              input int last);
    int idx;
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      idx = rr ? (last + 1 + k) % 4 : k;
      if (e[idx] && pick < 0) pick = idx;
    end
  endfunction

  // Monitor: reads appear the cycle after the address is sampled.
  always @(posedge clk)
    rd_flag <= !rst && !we && (addr[7:2] == 6'h38);

  always @(negedge clk) begin
    if (mon_on) begin
      if (irq_ack != 4'h0) begin
        if (exp_ack.size() == 0)
          chk("irq_ack_unexpected", irq_ack, 4'h0);
        else
          chk("irq_ack", irq_ack, exp_ack.pop_front());
      end
      if (rd_flag) begin
        if (exp_rd.size() == 0)
          chk("bus_rd_unexpected", 32'd1, 32'd0);
        else
          chk("bus_rd", bus_data, exp_rd.pop_front());
      end else if (!tb_drv) begin
        chk("bus_z", bus_data, 8'hFF);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) tick();
    rst    = 1'b0;
    m_pend = 4'h0;
    m_mask = 4'h0;
    m_mode = 1'b0;
    m_last = 3;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr     = a;
    we       = 1'b1;
    tb_drv   = 1'b1;
    tb_wdata = d;
    tick();
    we     = 1'b0;
    tb_drv = 1'b0;
    addr   = 8'h00;
    if (a == A_CTRL) begin
      m_mask = d[3:0];
      m_mode = d[7];
    end
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] e);
    exp_rd.push_back(e);
    addr = a;
    we   = 1'b0;
    tick();
    addr = 8'h00;
    tick();
  endtask

  task automatic pulse(input logic [3:0] r);
    raise = r;
    tick();
    raise  = 4'h0;
    m_pend = m_pend | r;
  endtask

  task automatic wait_raise(input int maxc, output int n);
    n = 0;
    while (!cpu_int_raise && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic ack_id(input int id);
    exp_ack.push_back(4'(1 << id));
    cpu_ack = 1'b1;
    tick();
    cpu_ack    = 1'b0;
    m_pend[id] = 1'b0;
    m_last     = id;
  endtask

  initial begin
    int n;
    int id;
    logic [7:0] d;
    logic [3:0] r;
    logic [3:0] elig;

    addr     = 8'h00;
    we       = 1'b0;
    raise    = 4'h0;
    cpu_ack  = 1'b0;
    tb_drv   = 1'b0;
    tb_wdata = 8'h00;
    do_reset(3);
    mon_on = 1'b1;

    chk("rst_cpu_int", cpu_int_raise, 1'b0);
    chk("rst_irq_ack", irq_ack, 4'h0);
    chk("rst_bus_z", bus_data, 8'hFF);
    bus_read(A_CTRL, 8'h00);
    bus_read(A_PEND, 8'h00);
    bus_read(A_CUR, 8'h00);
    bus_read(A_EOI, 8'h00);

    // Fixed priority, two simultaneous sources
    bus_write(A_CTRL, 8'h03);
    pulse(4'b0011);
    wait_raise(4, n);
    chk("fixed_latency", n, 1);
    chk("fixed_raise0", cpu_int_raise, 1'b1);
    ack_id(0);
    bus_read(A_CUR, 8'h80);
    bus_read(A_PEND, 8'h02);
    bus_write(A_EOI, 8'h00);
    wait_raise(4, n);
    chk("fixed_raise1", cpu_int_raise, 1'b1);
    ack_id(1);
    bus_read(A_CUR, 8'h81);
    bus_write(A_EOI, 8'h00);

    // Round-robin with both sources held high
    bus_write(A_CTRL, 8'h83);
    raise = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      wait_raise(6, n);
      chk("rr_raise", cpu_int_raise, 1'b1);
      ack_id(k % 2);
      if (k < 3) bus_write(A_EOI, 8'h00);
    end
    raise  = 4'h0;
    m_pend = 4'b0001;
    bus_read(A_CUR, 8'h81);
    bus_read(A_PEND, 8'h01);

    // Reset while in service
    do_reset(1);
    chk("svc_rst_cpu_int", cpu_int_raise, 1'b0);
    chk("svc_rst_bus_z", bus_data, 8'hFF);
    bus_read(A_CTRL, 8'h00);
    bus_read(A_PEND, 8'h00);
    bus_read(A_CUR, 8'h00);

    // Read timing and spurious EOI in IDLE
    pulse(4'b1000);
    bus_read(A_PEND, 8'h08);
    bus_write(A_EOI, 8'h00);
    tick();
    chk("eoi_idle_cpu_int", cpu_int_raise, 1'b0);
    bus_read(A_CUR, 8'h00);

    // Withdraw while raised
    bus_write(A_CTRL, 8'h02);
    pulse(4'b0010);
    wait_raise(4, n);
    chk("wd_raise", cpu_int_raise, 1'b1);
    bus_write(A_CTRL, 8'h00);
    tick();
    chk("wd_fall", cpu_int_raise, 1'b0);
    bus_write(A_EOI, 8'h00);
    bus_write(A_CTRL, 8'h02);
    wait_raise(3, n);
    chk("wd_reraise", cpu_int_raise, 1'b1);
    chk("wd_reraise_lat", n <= 2, 1'b1);
    ack_id(1);
    bus_read(A_CUR, 8'h81);
    bus_write(A_EOI, 8'h00);

    // Masked source
    do_reset(2);
    bus_write(A_CTRL, 8'h01);
    pulse(4'b0100);
    tick();
    tick();
    chk("mask_cpu_int", cpu_int_raise, 1'b0);
    bus_read(A_PEND, 8'h04);
    chk("mask_cpu_int2", cpu_int_raise, 1'b0);
    bus_write(A_CTRL, 8'h05);
    wait_raise(2, n);
    chk("unmask_raise", cpu_int_raise, 1'b1);
    ack_id(2);
    bus_read(A_CUR, 8'h82);
    bus_write(A_EOI, 8'h00);

    // Randomized rounds against the model
    for (int rnd = 0; rnd < 60; rnd++) begin
      repeat (3) tick();
      if (!cpu_int_raise) begin
        r = 4'($urandom_range(0, 15));
        if (r != 4'h0) pulse(r);
      end
      elig = m_pend & m_mask;
      wait_raise(4, n);
      chk("rand_raise", cpu_int_raise, elig != 4'h0);
      if (cpu_int_raise && elig != 4'h0) begin
        id = pick(elig, m_mode, m_last);
        ack_id(id);
        bus_read(A_CUR, 8'h80 | 8'(id));
        bus_read(A_PEND, {4'h0, m_pend});
        if ($urandom_range(0, 1) == 1) begin
          d = 8'($urandom);
          bus_write(A_CTRL, d);
          bus_read(A_CTRL, d & 8'h8F);
        end
        bus_write(A_EOI, 8'h00);
      end else if (cpu_int_raise) begin
        do_reset(1);
      end else if ($urandom_range(0, 2) == 0) begin
        d = 8'($urandom);
        bus_write(A_CTRL, d);
        bus_read(A_CTRL, d & 8'h8F);
      end
    end

    repeat (4) tick();
    chk("ack_queue_empty", exp_ack.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
